// File: rtl/shift_deserializer_pkg.sv
// Constants shared between the shift_deserializer and the upstream 8-bit shift register.
// Frame geometry defaults and the receive FSM state encoding live here.
package shift_deserializer_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_SKEW  = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_deserializer_sync_delay.sv
// DEPTH-stage delay line for the frame-start pulse; a synchronous active-low clear
// drops any pulse still in flight.
module sync_delay #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] stage_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver for an LSB-first frame stream, with a one-word output
// holding register behind a valid/ready handshake and sticky overrun/frame error flags.
module shift_deserializer
   import shift_deserializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SKEW  = DEFAULT_SKEW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             sync,
   input  logic             ready,
   input  logic             clr_err,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;

   logic             start;
   logic [WIDTH-1:0] shift_word;
   logic             complete;
   logic             ferr_ev;
   logic             ovr_ev;

   // The (SKEW+1)-stage line lands the pulse exactly on the bit-0 sampling edge.
   sync_delay #(
      .DEPTH (SKEW + 1)
   ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .d   (sync),
      .q   (start)
   );

   assign shift_word = {serial_in, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      complete = 1'b0;
      ferr_ev  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = shift_word;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = shift_word;
            if (start) begin
               // A restart mid-frame reuses the current bit as bit 0 of the new frame.
               cnt_d   = CW'(1);
               ferr_ev = 1'b1;
            end else if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d    = CW'(WIDTH);
               complete = 1'b1;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_ev  = 1'b0;
      if (complete) begin
         if (!valid_q || ready) begin
            data_d  = shift_word;
            valid_d = 1'b1;
         end else begin
            ovr_ev = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      // A new error event takes priority over a simultaneous clear.
      ovr_d  = ovr_ev  ? 1'b1 : (clr_err ? 1'b0 : ovr_q);
      ferr_d = ferr_ev ? 1'b1 : (clr_err ? 1'b0 : ferr_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign overrun   = ovr_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Schedule-driven bench: directed frames followed by random traffic, checked each cycle
// against an edge-indexed model of frame timing, plus a small WIDTH=4/SKEW=0 instance.
module tb_shift_deserializer;

   localparam int W  = 8;
   localparam int SK = 1;
   localparam int N  = 2200;

   logic       clk;
   logic       rst;
   logic       serial_in;
   logic       sync;
   logic       ready;
   logic       clr_err;
   logic [7:0] data_out;
   logic       valid;
   logic       overrun;
   logic       frame_err;

   logic       s2_ser;
   logic       s2_sync;
   logic [3:0] s2_data;
   logic       s2_valid;
   logic       s2_ovr;
   logic       s2_ferr;

   bit sch_sync [N];
   bit sch_ser  [N];
   bit sch_rst  [N];
   bit sch_rdy  [N];
   bit sch_clr  [N];
   bit sch2_sync[N];
   bit sch2_ser [N];

   int vectors;
   int miscompares;

   int         open_s;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ovr;
   logic       m_ferr;

   shift_deserializer #(.WIDTH(W), .SKEW(SK)) dut (
      .clk       (clk),
      .rst       (rst),
      .serial_in (serial_in),
      .sync      (sync),
      .ready     (ready),
      .clr_err   (clr_err),
      .data_out  (data_out),
      .valid     (valid),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   shift_deserializer #(.WIDTH(4), .SKEW(0)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .serial_in (s2_ser),
      .sync      (s2_sync),
      .ready     (1'b1),
      .clr_err   (1'b0),
      .data_out  (s2_data),
      .valid     (s2_valid),
      .overrun   (s2_ovr),
      .frame_err (s2_ferr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Sync sampled at edge es puts bit k on the wire for edge es+1+SK+k.
   task automatic plan(input int es, input logic [7:0] w);
      sch_sync[es] = 1'b1;
      for (int k = 0; k < W; k++) sch_ser[es + 1 + SK + k] = w[k];
   endtask

   task automatic plan4(input int es, input logic [3:0] w);
      sch2_sync[es] = 1'b1;
      for (int k = 0; k < 4; k++) sch2_ser[es + 1 + k] = w[k];
   endtask

   task automatic model_step(input int e);
      bit         st;
      bit         comp;
      bit         fe;
      bit         ov;
      int         n;
      logic [7:0] word;
      word = '0;
      if (!sch_rst[e]) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_ovr   = 1'b0;
         m_ferr  = 1'b0;
         open_s  = -1;
      end else begin
         st = 1'b0;
         n  = e - 1 - SK;
         if (n >= 0 && sch_sync[n]) begin
            st = 1'b1;
            for (int j = n; j <= e; j++) if (!sch_rst[j]) st = 1'b0;
         end
         comp = 1'b0;
         fe   = 1'b0;
         ov   = 1'b0;
         if (st) begin
            if (open_s >= 0) fe = 1'b1;
            open_s = e;
         end else if (open_s >= 0 && e - open_s == W - 1) begin
            comp = 1'b1;
            for (int k = 0; k < W; k++) word[k] = sch_ser[open_s + k];
            open_s = -1;
         end
         if (comp) begin
            if (!m_valid || sch_rdy[e]) begin
               m_data  = word;
               m_valid = 1'b1;
               $display("edge %0d: word %h delivered", e, word);
            end else begin
               ov = 1'b1;
               $display("edge %0d: word %h dropped", e, word);
            end
         end else if (m_valid && sch_rdy[e]) begin
            m_valid = 1'b0;
         end
         m_ovr  = ov ? 1'b1 : (sch_clr[e] ? 1'b0 : m_ovr);
         m_ferr = fe ? 1'b1 : (sch_clr[e] ? 1'b0 : m_ferr);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      open_s      = -1;
      m_valid     = 1'b0;
      m_data      = '0;
      m_ovr       = 1'b0;
      m_ferr      = 1'b0;
      rst         = 1'b0;
      serial_in   = 1'b0;
      sync        = 1'b0;
      ready       = 1'b1;
      clr_err     = 1'b0;
      s2_ser      = 1'b0;
      s2_sync     = 1'b0;

      for (int e = 0; e < N; e++) begin
         sch_sync[e]  = 1'b0;
         sch_ser[e]   = 1'b0;
         sch_rst[e]   = (e >= 2);
         sch_rdy[e]   = 1'b1;
         sch_clr[e]   = 1'b0;
         sch2_sync[e] = 1'b0;
         sch2_ser[e]  = 1'b0;
      end

      plan(10, 8'hA5);
      plan(30, 8'h01);
      plan(38, 8'h80);
      plan(46, 8'hFF);
      plan(54, 8'h3C);
      for (int e = 70; e < 96; e++) sch_rdy[e] = (e == 92);
      plan(70, 8'h11);
      plan(80, 8'h22);
      sch_clr[95] = 1'b1;
      plan(100, 8'hE7);
      plan(104, 8'h5A);
      sch_clr[115] = 1'b1;
      plan(120, 8'h77);
      sch_rst[125] = 1'b0;
      plan(130, 8'hC3);

      for (int e = 150; e < 1150; e++) begin
         sch_sync[e] = ($urandom_range(0, 9) == 0);
         sch_ser[e]  = 1'($urandom_range(0, 1));
         sch_rst[e]  = ($urandom_range(0, 299) != 0);
         sch_rdy[e]  = ($urandom_range(0, 3) != 0);
         sch_clr[e]  = ($urandom_range(0, 24) == 0);
      end
      for (int e = 1150; e < N; e++) begin
         sch_rdy[e] = ($urandom_range(0, 4) != 0);
         sch_clr[e] = ($urandom_range(0, 49) == 0);
      end
      for (int es = 1160; es + 1 + SK + W < N - 20; es += W) begin
         plan(es, 8'($urandom_range(0, 255)));
      end

      plan4(10, 4'h9);
      plan4(14, 4'h6);

      for (int e = 0; e < N; e++) begin
         @(negedge clk);
         rst       = sch_rst[e];
         sync      = sch_sync[e];
         serial_in = sch_ser[e];
         ready     = sch_rdy[e];
         clr_err   = sch_clr[e];
         s2_sync   = sch2_sync[e];
         s2_ser    = sch2_ser[e];
         @(posedge clk);
         #1;
         model_step(e);
         vectors++;
         chk($sformatf("e%0d_valid", e), 32'(valid), 32'(m_valid));
         chk($sformatf("e%0d_data", e), 32'(data_out), 32'(m_data));
         chk($sformatf("e%0d_overrun", e), 32'(overrun), 32'(m_ovr));
         chk($sformatf("e%0d_frame_err", e), 32'(frame_err), 32'(m_ferr));

         case (e)
            1: begin
               chk("reset_outputs", {data_out, valid, overrun, frame_err}, 32'h0);
               chk("reset_model", {m_data, m_valid, m_ovr, m_ferr}, 32'h0);
            end
            18: chk("t1_not_yet", 32'(valid), 32'h0);
            19: begin
               chk("t1_valid", 32'(valid), 32'h1);
               chk("t1_data", 32'(data_out), 32'hA5);
               chk("t1_model", 32'(m_data), 32'hA5);
               chk("t1_flags", {overrun, frame_err}, 32'h0);
            end
            20: chk("t1_pulse", 32'(valid), 32'h0);
            63: begin
               chk("t2_data", 32'(data_out), 32'h3C);
               chk("t2_ferr", 32'(frame_err), 32'h0);
            end
            89: begin
               chk("t3_data", 32'(data_out), 32'h11);
               chk("t3_overrun", 32'(overrun), 32'h1);
               chk("t3_model", {m_data, m_ovr}, {23'h0, 8'h11, 1'b1});
            end
            92: chk("t3_drop", {data_out, valid}, {23'h0, 8'h11, 1'b0});
            95: chk("t3_clr", 32'(overrun), 32'h0);
            106: chk("t4_ferr", 32'(frame_err), 32'h1);
            109: chk("t4_no_word", 32'(valid), 32'h0);
            113: begin
               chk("t4_data", {data_out, valid}, {23'h0, 8'h5A, 1'b1});
               chk("t4_model", 32'(m_data), 32'h5A);
            end
            115: chk("t4_clr", 32'(frame_err), 32'h0);
            125: chk("t5_reset", {data_out, valid, overrun, frame_err}, 32'h0);
            129: chk("t5_no_word", 32'(valid), 32'h0);
            139: chk("t5_data", {data_out, valid}, {23'h0, 8'hC3, 1'b1});
            13: chk("t6_not_yet", 32'(s2_valid), 32'h0);
            14: chk("t6_word9", {s2_data, s2_valid}, {27'h0, 4'h9, 1'b1});
            15: chk("t6_pulse", 32'(s2_valid), 32'h0);
            18: ;
            default: ;
         endcase
         if (e == 18) chk("t6_word6", {s2_data, s2_valid, s2_ferr}, {26'h0, 4'h6, 1'b1, 1'b0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver that sits directly downstream of the team's 8-bit LSB-first shift register. It samples the serial bit stream, reassembles each frame into a parallel word, and presents it to the consumer through a valid/ready handshake. The block takes the same `sync` pulse that drives the shift register's `load`, and compensates internally for the serializer's pipeline delay. It flags lost words and broken frames with sticky error bits.

## Interface
- `WIDTH`, 8: bits per frame. Must be ≥ 2.
- `SKEW`, 1: extra cycles between the edge that samples `sync` and the edge that samples bit 0, beyond the first cycle. The value 1 matches the shift register. Must be ≥ 0.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `serial_in`  in  1  serial data, LSB first.
- `sync`  in  1  frame-start pulse, the same signal as the serializer's `load`.
- `ready`  in  1  consumer accepts `data_out` when `valid && ready`.
- `clr_err`  in  1  clears `overrun` and `frame_err`.
- `data_out`  out  WIDTH  last completed word.
- `valid`  out  1  `data_out` holds an unaccepted word.
- `overrun`  out  1  sticky; a completed word was dropped.
- `frame_err`  out  1  sticky; a frame was aborted by a new start.

## Operation
- **Delay line.**
  - `sync` passes through a (SKEW+1)-stage delay line; its output is `start`.
  - `start` is high at exactly the edge where bit 0 must be sampled.
- **FSM states.** IDLE and SHIFT.
  - IDLE:
    - `start` = 1: shift `serial_in` into the MSB of `shreg`, set `cnt` = 1, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT, `start` = 0:
    - Shift right, inserting `serial_in` at the MSB, and set `cnt` = `cnt` + 1.
    - When the shift brings `cnt` to WIDTH, the frame is complete. The word goes to the output holding register and the FSM returns to IDLE.
  - SHIFT, `start` = 1 (mid-frame):
    - Discard the partial word and set `frame_err`.
    - The current bit becomes bit 0 of a new frame: `cnt` = 1, stay in SHIFT.
- **Back-to-back frames.** `start` in the edge right after the last bit of a frame is a normal frame start, not an error. This is the case when `sync` fires every WIDTH cycles.
- **Output handshake.**
  - On completion with `valid` = 0, or with `valid && ready` in the same cycle: load `data_out`; `valid` is 1 after the edge.
  - On completion with `valid` = 1 and `ready` = 0: drop the new word, keep `data_out` unchanged, set `overrun`.
  - `valid && ready` with no completion: `valid` goes to 0 after the edge; `data_out` holds its value.
- **Error flags.** `clr_err` clears both flags. If an error event and `clr_err` occur in the same cycle, the set wins.
- **Reset** (`rst` = 0 at an edge), any time including mid-frame:
  - State goes to IDLE, `cnt` to 0, `shreg` to 0.
  - The delay line is cleared, so any pending `sync` is lost.
  - `data_out` = 0, `valid` = 0, `overrun` = 0, `frame_err` = 0.
- **Widths.**
  - `cnt` is $clog2(WIDTH+1) bits; it never exceeds WIDTH and never wraps.
  - `data_out[i]` is bit i of the serial frame.

## Timing
- `sync` sampled high at edge n means bit k is sampled at edge n+1+SKEW+k.
- The last bit is sampled at edge n+SKEW+WIDTH; `valid` rises after that same edge. With defaults: edge n+9.
- Throughput is one word per WIDTH cycles, continuously, with no bubbles.
- `ready` may be held high permanently; `valid` then pulses one cycle per word.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared constants file holds:
  - the default frame width (8) and default skew (1), shared with the shift register;
  - the FSM state encodings IDLE = 1'b0, SHIFT = 1'b1.
- One sub-module, `sync_delay`: parameterised DEPTH-stage shift line with synchronous active-low clear. It is instantiated with DEPTH = SKEW+1.
- Everything else stays in the top module: FSM, counter, `shreg`, holding register, flags.

## Test plan
1. Defaults, `ready` = 1. Pulse `sync` at edge 10 and drive the serial bits of 8'hA5 at edges 12..19 (bit 0 at edge 12). Expect `valid` = 1 for one cycle after edge 19 with `data_out` = 8'hA5, and no flags set.
2. Continuous stream. Pulse `sync` every 8 cycles carrying 8'h01, 8'h80, 8'hFF, 8'h3C. Expect four words in order, one `valid` per 8 cycles, and `frame_err` = 0.
3. `ready` = 0. Send 8'h11 then 8'h22. Expect `data_out` = 8'h11 held and `overrun` = 1 after the second word completes. Then raise `ready` for 1 cycle: `valid` drops and `data_out` stays 8'h11.
4. Mid-frame restart. Send `sync` 4 cycles after the previous one, carrying 8'h5A. Expect `frame_err` = 1 and the only word delivered to be 8'h5A. Then `clr_err` = 1 gives `frame_err` = 0 the next cycle.
5. Apply `rst` = 0 for 1 cycle while 3 bits of a frame are already in. Expect all outputs to be 0 after the edge and no word delivered. The next frame 8'hC3 is received correctly.
6. Build with SKEW = 0 and WIDTH = 4. Pulse `sync` at edge n and drive 4'h9 starting at edge n+1. Expect `valid` after edge n+4 with `data_out` = 4'h9.
